// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: zero-pads frames to MIN_FRAME, appends the CRC32 FCS and enforces an IFG.
// Optional preamble/SFD generation is enabled by defining ETH_TX_PREAMBLE_EN.
module eth_tx_framer #(
    parameter int MIN_FRAME  = 60,
    parameter int MAX_FRAME  = 1514,
    parameter int IFG_CYCLES = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       busy,
    output logic       oversize_err,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        ST_DATA = 3'd0,
        ST_PAD  = 3'd1,
        ST_FCS  = 3'd2,
`ifdef ETH_TX_PREAMBLE_EN
        ST_PRE  = 3'd4,
`endif
        ST_IFG  = 3'd3
    } state_t;

`ifdef ETH_TX_PREAMBLE_EN
    localparam state_t ST_IDLE = ST_PRE;
`else
    localparam state_t ST_IDLE = ST_DATA;
`endif

    localparam int               IFG_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam logic [11:0]      MIN_L    = 12'(MIN_FRAME);
    localparam logic [11:0]      MAX_P1   = 12'(MAX_FRAME + 1);
    localparam logic [31:0]      CRC_INIT = 32'hFFFF_FFFF;

    state_t           state_q, state_d;
    logic [10:0]      count_q, count_d;
    logic [31:0]      crc_q, crc_d;
    logic [1:0]       idx_q, idx_d;
    logic [IFG_W-1:0] ifg_q, ifg_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
`ifdef ETH_TX_PREAMBLE_EN
    logic             pre_act_q, pre_act_d;
    logic [2:0]       pre_idx_q, pre_idx_d;
`endif

    logic [7:0]  tdata;
    logic        tvalid, tready, tlast, done, oversize;
    logic [11:0] cnt_p1;
    logic [10:0] count_inc;
    logic [31:0] fcs;
    logic        ifg_done;

    // Reflected CRC32 (poly 0xEDB88320) advanced by one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    assign cnt_p1    = {1'b0, count_q} + 12'd1;
    assign count_inc = (count_q == 11'h7FF) ? count_q : cnt_p1[10:0];
    assign fcs       = ~crc_q;
    assign ifg_done  = (IFG_CYCLES <= 1) || (ifg_q == IFG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= 11'd0;
            crc_q     <= CRC_INIT;
            idx_q     <= 2'd0;
            ifg_q     <= '0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef ETH_TX_PREAMBLE_EN
            pre_act_q <= 1'b0;
            pre_idx_q <= 3'd0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            crc_q     <= crc_d;
            idx_q     <= idx_d;
            ifg_q     <= ifg_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
`ifdef ETH_TX_PREAMBLE_EN
            pre_act_q <= pre_act_d;
            pre_idx_q <= pre_idx_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        crc_d     = crc_q;
        idx_d     = idx_q;
        ifg_d     = ifg_q;
        busy_d    = busy_q;
        ovf_d     = ovf_q;
`ifdef ETH_TX_PREAMBLE_EN
        pre_act_d = pre_act_q;
        pre_idx_d = pre_idx_q;
`endif
        tdata     = 8'h00;
        tvalid    = 1'b0;
        tready    = 1'b0;
        tlast     = 1'b0;
        done      = 1'b0;
        oversize  = 1'b0;

        case (state_q)
`ifdef ETH_TX_PREAMBLE_EN
            ST_PRE: begin
                // Preamble only starts once the source has a frame waiting.
                tdata  = (pre_idx_q == 3'd7) ? 8'hD5 : 8'h55;
                tvalid = pre_act_q;
                if (!pre_act_q) begin
                    if (s_axis_tvalid) begin
                        pre_act_d = 1'b1;
                        busy_d    = 1'b1;
                    end
                end else if (m_axis_tready) begin
                    pre_idx_d = pre_idx_q + 3'd1;
                    if (pre_idx_q == 3'd7) begin
                        pre_act_d = 1'b0;
                        state_d   = ST_DATA;
                    end
                end
            end
`endif
            ST_DATA: begin
                tdata  = s_axis_tdata;
                tvalid = s_axis_tvalid;
                tready = m_axis_tready;
                if (s_axis_tvalid && m_axis_tready) begin
                    count_d = count_inc;
                    crc_d   = crc_byte(crc_q, s_axis_tdata);
                    busy_d  = 1'b1;
                    if (!ovf_q && (cnt_p1 == MAX_P1)) begin
                        oversize = 1'b1;
                        ovf_d    = 1'b1;
                    end
                    if (s_axis_tlast) begin
                        idx_d   = 2'd0;
                        state_d = (cnt_p1 < MIN_L) ? ST_PAD : ST_FCS;
                    end
                end
            end
            ST_PAD: begin
                tvalid = 1'b1;
                if (m_axis_tready) begin
                    count_d = count_inc;
                    crc_d   = crc_byte(crc_q, 8'h00);
                    if (cnt_p1 == MIN_L) begin
                        state_d = ST_FCS;
                    end
                end
            end
            ST_FCS: begin
                tvalid = 1'b1;
                tlast  = (idx_q == 2'd3);
                case (idx_q)
                    2'd0:    tdata = fcs[7:0];
                    2'd1:    tdata = fcs[15:8];
                    2'd2:    tdata = fcs[23:16];
                    default: tdata = fcs[31:24];
                endcase
                if (m_axis_tready) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        done    = 1'b1;
                        ifg_d   = '0;
                        state_d = ST_IFG;
                    end
                end
            end
            ST_IFG: begin
                if (ifg_done) begin
                    count_d = 11'd0;
                    crc_d   = CRC_INIT;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    ifg_d = ifg_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs are forced low for the whole time reset is asserted.
    assign m_axis_tdata  = tdata;
    assign m_axis_tvalid = rst_n & tvalid;
    assign m_axis_tlast  = rst_n & tlast;
    assign s_axis_tready = rst_n & tready;
    assign frame_done    = rst_n & done;
    assign oversize_err  = rst_n & oversize;
    assign busy          = busy_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: a whole-frame reference model fills expectation queues,
// monitors pop and compare on every output handshake.
`timescale 1ns/1ps
module tb_eth_tx_framer;
    localparam int MINF = 60;
    localparam int MAXF = 1514;
    localparam int IFG  = 12;

    typedef struct {
        logic [7:0] d;
        bit         last;
        bit         ovf;
        bit         nd;
        int         fi;
    } beat_t;
    typedef beat_t beat_q_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid, m_tlast, m_tready;
    logic       busy, oversize_err, frame_done;

    logic [7:0] s2_tdata = 8'h00;
    logic       s2_tvalid = 1'b0, s2_tlast = 1'b0, s2_tready;
    logic [7:0] m2_tdata;
    logic       m2_tvalid, m2_tlast;
    logic       m2_tready = 1'b1;
    logic       busy2, oversize2, frame_done2;

    int         total = 0;
    int         bad = 0;
    beat_t      exp_q[$];
    logic [8:0] exp2_q[$];
    bit         rand_rdy = 1'b0;
    bit         fcs0_seen = 1'b0;
    int         done2 = 0;

    always #5 clk = ~clk;

    eth_tx_framer #(.MIN_FRAME(MINF), .MAX_FRAME(MAXF), .IFG_CYCLES(IFG)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .busy(busy), .oversize_err(oversize_err), .frame_done(frame_done)
    );

    eth_tx_framer #(.MIN_FRAME(0), .MAX_FRAME(MAXF), .IFG_CYCLES(2)) u_nopad (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready), .s_axis_tlast(s2_tlast),
        .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready), .m_axis_tlast(m2_tlast),
        .busy(busy2), .oversize_err(oversize2), .frame_done(frame_done2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // Bit-serial CRC32 of the whole message, returned already inverted (the FCS value).
    function automatic logic [31:0] ref_fcs(input logic [7:0] b[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    function automatic beat_q_t expect_beats(input logic [7:0] b[$], input int minf);
        beat_q_t     o;
        logic [7:0]  p[$];
        logic [31:0] f;
        beat_t       e;
`ifdef ETH_TX_PREAMBLE_EN
        for (int i = 0; i < 8; i++) begin
            e = '{(i == 7) ? 8'hD5 : 8'h55, 1'b0, 1'b0, 1'b1, -1};
            o.push_back(e);
        end
`endif
        p = b;
        for (int i = 0; i < b.size(); i++) begin
            e = '{b[i], 1'b0, (i + 1 == MAXF + 1), 1'b0, -1};
            o.push_back(e);
        end
        while (p.size() < minf) begin
            p.push_back(8'h00);
            e = '{8'h00, 1'b0, 1'b0, 1'b1, -1};
            o.push_back(e);
        end
        f = ref_fcs(p);
        for (int k = 0; k < 4; k++) begin
            e = '{f[8*k +: 8], (k == 3), 1'b0, 1'b1, k};
            o.push_back(e);
        end
        return o;
    endfunction

    task automatic send(input logic [7:0] b[$], input bit gaps);
        beat_q_t e;
        bit      hs;
        int      n;
        e = expect_beats(b, MINF);
        foreach (e[i]) exp_q.push_back(e[i]);
        for (int i = 0; i < b.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                @(posedge clk); #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = b[i];
            s_tlast  = (i == b.size() - 1);
            hs = 1'b0;
            n  = 0;
            while (!hs && n < 5000) begin
                @(negedge clk);
                hs = s_tready;
                @(posedge clk); #1;
                n++;
            end
            if (!hs) begin
                chk("src_handshake", hs, 1);
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    int         ifg_left = 0;
    bit         busy_chk = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_d;
    logic       prev_l;

    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            ifg_left   = 0;
            busy_chk   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_tvalid_held", m_tvalid, 1);
                chk("stall_tdata_stable", m_tdata, prev_d);
                chk("stall_tlast_stable", m_tlast, prev_l);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
            prev_l     = m_tlast;
            if (ifg_left > 0) begin
                chk("ifg_tvalid_low", m_tvalid, 0);
                chk("ifg_tready_low", s_tready, 0);
                chk("ifg_busy_high", busy, 1);
                ifg_left--;
            end else if (busy_chk) begin
                chk("busy_clear_after_ifg", busy, 0);
                busy_chk = 1'b0;
            end
            if (exp_q.size() > 0 && exp_q[0].nd) chk("s_tready_low_pad_fcs", s_tready, 0);
            if (m_tvalid && m_tready) begin
                chk("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("tdata", m_tdata, e.d);
                    chk("tlast", m_tlast, e.last);
                    chk("frame_done", frame_done, e.last);
                    chk("oversize_err", oversize_err, e.ovf);
                    if (e.fi >= 0) chk("busy_in_fcs", busy, 1);
                    if (e.fi == 0) fcs0_seen = 1'b1;
                    if (e.last) begin
                        ifg_left = IFG;
                        busy_chk = 1'b1;
                    end
                end
            end else begin
                chk("frame_done_idle", frame_done, 0);
                chk("oversize_idle", oversize_err, 0);
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0] x;
        if (rst_n && frame_done2) done2++;
        if (rst_n && m2_tvalid && m2_tready) begin
            chk("nopad_beat_expected", exp2_q.size() > 0, 1);
            if (exp2_q.size() > 0) begin
                x = exp2_q.pop_front();
                chk("nopad_tdata", m2_tdata, x[7:0]);
                chk("nopad_tlast", m2_tlast, x[8]);
                chk("nopad_frame_done", frame_done2, x[8]);
            end
        end
    end

    initial begin
        logic [7:0] fcs_bytes[4];
        bit         hs;
        int         n;
        fcs_bytes = '{8'h26, 8'h39, 8'hF4, 8'hCB};
`ifdef ETH_TX_PREAMBLE_EN
        for (int i = 0; i < 8; i++) exp2_q.push_back({1'b0, (i == 7) ? 8'hD5 : 8'h55});
`endif
        for (int i = 0; i < 9; i++) exp2_q.push_back({1'b0, 8'h31 + 8'(i)});
        for (int k = 0; k < 4; k++) exp2_q.push_back({(k == 3), fcs_bytes[k]});
        @(posedge rst_n);
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            s2_tvalid = 1'b1;
            s2_tdata  = 8'h31 + 8'(i);
            s2_tlast  = (i == 8);
            hs = 1'b0;
            n  = 0;
            while (!hs && n < 500) begin
                @(negedge clk);
                hs = s2_tready;
                @(posedge clk); #1;
                n++;
            end
            if (!hs) begin
                chk("nopad_src_handshake", hs, 1);
                break;
            end
        end
        s2_tvalid = 1'b0;
        s2_tlast  = 1'b0;
    end

    initial begin
        logic [7:0] b[$];
        int         n;
        s_tvalid = 1'b1;
        s_tdata  = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_m_tvalid", m_tvalid, 0);
        chk("reset_m_tlast", m_tlast, 0);
        chk("reset_s_tready", s_tready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_oversize", oversize_err, 0);
        chk("reset_frame_done", frame_done, 0);
        s_tvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        b = '{8'hAB};
        send(b, 1'b0);
        b.delete();
        for (int i = 0; i < 100; i++) b.push_back(8'(i));
        send(b, 1'b0);
        b.delete();
        for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
        send(b, 1'b0);

        rand_rdy = 1'b1;
        repeat (3) begin
            b.delete();
            n = $urandom_range(1, 120);
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            send(b, 1'b1);
        end
        wait_drain();
        rand_rdy = 1'b0;

        b.delete();
        for (int i = 0; i < 1600; i++) b.push_back(8'(i));
        send(b, 1'b0);
        wait_drain();

        b.delete();
        for (int i = 0; i < 70; i++) b.push_back(8'($urandom));
        fcs0_seen = 1'b0;
        send(b, 1'b0);
        n = 0;
        while (!fcs0_seen && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("reached_fcs_index1", fcs0_seen, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_m_tvalid", m_tvalid, 0);
        chk("midreset_m_tlast", m_tlast, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_s_tready", s_tready, 0);
        repeat (2) @(posedge clk);
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        b.delete();
        for (int i = 0; i < 9; i++) b.push_back(8'h31 + 8'(i));
        send(b, 1'b0);
        wait_drain();
        repeat (IFG + 4) @(posedge clk);

        chk("final_queue_empty", exp_q.size(), 0);
        chk("nopad_queue_empty", exp2_q.size(), 0);
        chk("nopad_frame_done_count", done2, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
